// File: rtl/xfcp_fpga_core.sv
// xfcp_fpga_core: UART byte-command register file driving board I/O, I2C bit-bang, PHY control and GMII loopback.
module xfcp_fpga_core #(
  parameter int CLK_FREQ = 125000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnu,
  input  logic       btnl,
  input  logic       btnd,
  input  logic       btnr,
  input  logic       btnc,
  input  logic [3:0] sw,
  output logic [7:0] led,
  input  logic       i2c_scl_i,
  output logic       i2c_scl_o,
  output logic       i2c_scl_t,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_t,
  input  logic       phy_gmii_clk,
  input  logic       phy_gmii_rst,
  input  logic       phy_gmii_clk_en,
  input  logic [7:0] phy_gmii_rxd,
  input  logic       phy_gmii_rx_dv,
  input  logic       phy_gmii_rx_er,
  output logic [7:0] phy_gmii_txd,
  output logic       phy_gmii_tx_en,
  output logic       phy_gmii_tx_er,
  output logic       phy_reset_n,
  input  logic       phy_int_n,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       uart_rts,
  input  logic       uart_cts
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  // rxd resets low so the receiver waits for a genuine idle line; cts resets high (not ready)
  localparam logic [13:0] SYNC_RST = 14'h2E00;
  typedef enum logic [2:0] {RX_WAIT, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_st_t;
  typedef enum logic [1:0] {C_IDLE, C_ADDR, C_DATA, C_RESP} cmd_st_t;
  logic [13:0] sync_in, meta_q, sync_q;
  logic rxd_s, cts_s;
  rx_st_t rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic rx_valid;
  tx_st_t tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic [9:0] tx_sh_q, tx_sh_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic tx_pend_q, tx_pend_d;
  logic tx_busy, tx_load;
  logic [7:0] tx_byte;
  cmd_st_t cmd_q, cmd_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [7:0] addr_q, addr_d;
  logic accept, reg_we;
  logic [7:0] rdata;
  logic [7:0] led_q;
  logic [1:0] i2c_q, ctrl_q;
  logic [9:0] gtx_q, gtx_d;
  logic dv_prev_q, dv_prev_d;
  logic [7:0] rxfrm_q, rxfrm_d, rxerr_q, rxerr_d;
  logic frm_inc, err_inc;
  logic unused_ok;
  assign unused_ok = phy_gmii_clk;
  assign sync_in = {uart_cts, uart_rxd, phy_int_n, i2c_sda_i, i2c_scl_i, sw, btnc, btnr, btnd, btnl, btnu};
  assign rxd_s = sync_q[12];
  assign cts_s = sync_q[13];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= SYNC_RST;
      sync_q <= SYNC_RST;
    end else begin
      meta_q <= sync_in;
      sync_q <= meta_q;
    end
  end
  always_comb begin
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_valid = 1'b0;
    case (rx_st_q)
      RX_WAIT: begin
        rx_cnt_d = '0;
        rx_st_d = rxd_s ? RX_IDLE : RX_WAIT;
      end
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_st_d = rxd_s ? RX_IDLE : RX_START;
      end
      RX_START: if (rx_cnt_q == HALF) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d = rxd_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == FULL) begin
        rx_cnt_d = '0;
        rx_sh_d = {rxd_s, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        rx_st_d = (rx_bit_q == 3'd7) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (rx_cnt_q == FULL) begin
        rx_cnt_d = '0;
        rx_valid = rxd_s;
        rx_st_d = rxd_s ? RX_IDLE : RX_WAIT;
      end
      default: rx_st_d = RX_WAIT;
    endcase
  end
  assign tx_busy = tx_pend_q || (tx_st_q != TX_IDLE);
  assign accept = rx_valid && !tx_busy;
  always_comb begin
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_buf_d = tx_load ? tx_byte : tx_buf_q;
    tx_pend_d = tx_pend_q | tx_load;
    if (tx_st_q == TX_IDLE) begin
      if (tx_pend_q && !cts_s) begin
        tx_st_d = TX_SEND;
        tx_sh_d = {1'b1, tx_buf_q, 1'b0};
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_pend_d = 1'b0;
      end
    end else if (tx_cnt_q == FULL) begin
      tx_cnt_d = '0;
      tx_sh_d = {1'b1, tx_sh_q[9:1]};
      tx_bit_d = tx_bit_q + 1'b1;
      tx_st_d = (tx_bit_q == 4'd9) ? TX_IDLE : TX_SEND;
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
  end
  always_comb begin
    cmd_d = cmd_q;
    wr_d = wr_q;
    err_d = err_q;
    addr_d = addr_q;
    reg_we = 1'b0;
    tx_load = 1'b0;
    case (cmd_q)
      C_IDLE: if (accept) begin
        wr_d = rx_sh_q == 8'h57;
        err_d = rx_sh_q != 8'h57 && rx_sh_q != 8'h52;
        cmd_d = err_d ? C_RESP : C_ADDR;
      end
      C_ADDR: if (accept) begin
        addr_d = rx_sh_q;
        cmd_d = wr_q ? C_DATA : C_RESP;
      end
      C_DATA: if (accept) begin
        reg_we = 1'b1;
        cmd_d = C_RESP;
      end
      default: begin
        tx_load = 1'b1;
        cmd_d = C_IDLE;
      end
    endcase
  end
  always_comb begin
    rdata = addr_q == 8'h00 ? led_q :
            addr_q == 8'h01 ? {3'b0, sync_q[4:0]} :
            addr_q == 8'h02 ? {4'b0, sync_q[8:5]} :
            addr_q == 8'h03 ? {4'b0, sync_q[10:9], i2c_q} :
            addr_q == 8'h04 ? {5'b0, sync_q[11], ctrl_q} :
            addr_q == 8'h05 ? rxfrm_q :
            addr_q == 8'h06 ? rxerr_q : 8'h00;
    tx_byte = err_q ? 8'h3F : wr_q ? 8'h4B : rdata;
  end
  // Bus clear and the loopback-disable both force the TX pins low ahead of data updates
  always_comb begin
    gtx_d = (phy_gmii_rst || !ctrl_q[1]) ? 10'd0 :
            phy_gmii_clk_en ? {phy_gmii_rxd, phy_gmii_rx_dv, phy_gmii_rx_er} : gtx_q;
    dv_prev_d = phy_gmii_rst ? 1'b0 : phy_gmii_clk_en ? phy_gmii_rx_dv : dv_prev_q;
    frm_inc = phy_gmii_clk_en && phy_gmii_rx_dv && !dv_prev_q;
    err_inc = phy_gmii_clk_en && phy_gmii_rx_dv && phy_gmii_rx_er && rxerr_q != 8'hFF;
    rxfrm_d = (phy_gmii_rst || (reg_we && addr_q == 8'h05)) ? 8'h00 : rxfrm_q + {7'b0, frm_inc};
    rxerr_d = (phy_gmii_rst || (reg_we && addr_q == 8'h06)) ? 8'h00 : rxerr_q + {7'b0, err_inc};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st_q <= RX_WAIT;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      tx_st_q <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '1;
      tx_buf_q <= '0;
      tx_pend_q <= 1'b0;
      cmd_q <= C_IDLE;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      gtx_q <= '0;
      dv_prev_q <= 1'b0;
      rxfrm_q <= '0;
      rxerr_q <= '0;
    end else begin
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_buf_q <= tx_buf_d;
      tx_pend_q <= tx_pend_d;
      cmd_q <= cmd_d;
      wr_q <= wr_d;
      err_q <= err_d;
      addr_q <= addr_d;
      gtx_q <= gtx_d;
      dv_prev_q <= dv_prev_d;
      rxfrm_q <= rxfrm_d;
      rxerr_q <= rxerr_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= 8'h00;
      i2c_q <= 2'b00;
      ctrl_q <= 2'b11;
    end else if (reg_we) begin
      if (addr_q == 8'h00) led_q <= rx_sh_q;
      if (addr_q == 8'h03) i2c_q <= rx_sh_q[1:0];
      if (addr_q == 8'h04) ctrl_q <= rx_sh_q[1:0];
    end
  end
  assign led = led_q;
  assign i2c_scl_o = 1'b0;
  assign i2c_sda_o = 1'b0;
  assign i2c_scl_t = ~i2c_q[0];
  assign i2c_sda_t = ~i2c_q[1];
  assign phy_reset_n = ~rst & ctrl_q[0];
  assign {phy_gmii_txd, phy_gmii_tx_en, phy_gmii_tx_er} = gtx_q;
  assign uart_txd = (tx_st_q == TX_SEND) ? tx_sh_q[0] : 1'b1;
  assign uart_rts = 1'b0;
endmodule

// File: tb/tb_xfcp_fpga_core.sv
// tb_xfcp_fpga_core: drives UART commands and GMII traffic, checks against a register-map model.
module tb_xfcp_fpga_core;
  localparam int DIV = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic btnu = 0, btnl = 0, btnd = 0, btnr = 0, btnc = 0;
  logic [3:0] sw = 0;
  logic [7:0] led;
  logic i2c_scl_i = 1, i2c_sda_i = 1, i2c_scl_o, i2c_sda_o, i2c_scl_t, i2c_sda_t;
  logic phy_gmii_rst = 0, phy_gmii_clk_en = 0, phy_gmii_rx_dv = 0, phy_gmii_rx_er = 0;
  logic [7:0] phy_gmii_rxd = 0, phy_gmii_txd;
  logic phy_gmii_tx_en, phy_gmii_tx_er, phy_reset_n;
  logic phy_int_n = 1, uart_rxd = 0, uart_txd, uart_rts, uart_cts = 0;
  int checks = 0, failures = 0;
  logic [7:0] rxq[$];
  logic [7:0] rx_b;
  logic [7:0] mdl_led = 8'h00;
  logic [1:0] mdl_i2c = 2'b00, mdl_ctrl = 2'b11;
  xfcp_fpga_core #(.CLK_FREQ(1600), .BAUD(100)) dut (
    .clk(clk), .rst(rst), .btnu(btnu), .btnl(btnl), .btnd(btnd), .btnr(btnr), .btnc(btnc),
    .sw(sw), .led(led), .i2c_scl_i(i2c_scl_i), .i2c_scl_o(i2c_scl_o), .i2c_scl_t(i2c_scl_t),
    .i2c_sda_i(i2c_sda_i), .i2c_sda_o(i2c_sda_o), .i2c_sda_t(i2c_sda_t),
    .phy_gmii_clk(clk), .phy_gmii_rst(phy_gmii_rst), .phy_gmii_clk_en(phy_gmii_clk_en),
    .phy_gmii_rxd(phy_gmii_rxd), .phy_gmii_rx_dv(phy_gmii_rx_dv), .phy_gmii_rx_er(phy_gmii_rx_er),
    .phy_gmii_txd(phy_gmii_txd), .phy_gmii_tx_en(phy_gmii_tx_en), .phy_gmii_tx_er(phy_gmii_tx_er),
    .phy_reset_n(phy_reset_n), .phy_int_n(phy_int_n), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .uart_rts(uart_rts), .uart_cts(uart_cts)
  );
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  initial forever begin
    @(negedge clk);
    if (uart_txd === 1'b0) begin
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        rx_b[i] = uart_txd;
      end
      repeat (DIV) @(negedge clk);
      if (uart_txd === 1'b1) rxq.push_back(rx_b);
    end
  end
  function automatic logic [7:0] exp_read(input logic [7:0] a);
    case (a)
      8'h00: return mdl_led;
      8'h01: return {3'b0, btnc, btnr, btnd, btnl, btnu};
      8'h02: return {4'b0, sw};
      8'h03: return {4'b0, i2c_sda_i, i2c_scl_i, mdl_i2c};
      8'h04: return {5'b0, phy_int_n, mdl_ctrl};
      default: return 8'h00;
    endcase
  endfunction
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (DIV) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask
  task automatic get_resp(output logic [8:0] r);
    int t = 0;
    while (rxq.size() == 0 && t < 60 * DIV) begin
      @(negedge clk);
      t++;
    end
    r = (rxq.size() != 0) ? {1'b0, rxq.pop_front()} : 9'h100;
  endtask
  task automatic rd(input logic [7:0] a, output logic [8:0] r);
    send_byte(8'h52, 1'b1);
    send_byte(a, 1'b1);
    get_resp(r);
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d, output logic [8:0] r);
    send_byte(8'h57, 1'b1);
    send_byte(a, 1'b1);
    send_byte(d, 1'b1);
    get_resp(r);
  endtask
  task automatic pulse(input int len, input logic er);
    phy_gmii_rx_dv = 1'b1;
    phy_gmii_rx_er = er;
    repeat (len) @(negedge clk);
    phy_gmii_rx_dv = 1'b0;
    phy_gmii_rx_er = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset;
    logic [25:0] got;
    repeat (3) @(negedge clk);
    checks++;
    if (phy_reset_n !== 1'b0) begin failures++; $display("FAIL rst_phy_reset_n got=%b exp=0", phy_reset_n); end
    rst = 1'b0;
    @(negedge clk);
    got = {led, i2c_scl_t, i2c_sda_t, i2c_scl_o, i2c_sda_o, phy_gmii_txd, phy_gmii_tx_en, phy_gmii_tx_er, uart_txd, uart_rts, phy_reset_n};
    checks++;
    if (got !== {8'h00, 4'b1100, 8'h00, 2'b00, 3'b101}) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", got, {8'h00, 4'b1100, 8'h00, 2'b00, 3'b101}); end
    repeat (20 * DIV) @(negedge clk);
    checks++;
    if (rxq.size() !== 0) begin failures++; $display("FAIL powerup_low_rxd got=%0d bytes exp=0", rxq.size()); end
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_write_led;
    logic [8:0] r;
    wr(8'h00, 8'hA5, r);
    mdl_led = 8'hA5;
    checks++;
    if (r !== 9'h04B) begin failures++; $display("FAIL led_write_ack got=%h exp=04b", r); end
    checks++;
    if (led !== 8'hA5) begin failures++; $display("FAIL led_pins got=%h exp=a5", led); end
  endtask
  task automatic test_inputs;
    logic [8:0] r;
    btnc = 1;
    sw = 4'h9;
    rd(8'h01, r);
    checks++;
    if (r !== 9'h010) begin failures++; $display("FAIL btn_read got=%h exp=010", r); end
    rd(8'h02, r);
    checks++;
    if (r !== 9'h009) begin failures++; $display("FAIL sw_read got=%h exp=009", r); end
    for (int i = 0; i < 3; i++) begin
      {btnc, btnr, btnd, btnl, btnu} = 5'($urandom);
      sw = 4'($urandom);
      rd(8'h01, r);
      checks++;
      if (r !== {1'b0, exp_read(8'h01)}) begin failures++; $display("FAIL btn_rand got=%h exp=%h", r, exp_read(8'h01)); end
      rd(8'h02, r);
      checks++;
      if (r !== {1'b0, exp_read(8'h02)}) begin failures++; $display("FAIL sw_rand got=%h exp=%h", r, exp_read(8'h02)); end
    end
  endtask
  task automatic test_i2c;
    logic [8:0] r;
    logic [7:0] d;
    wr(8'h03, 8'h02, r);
    mdl_i2c = 2'b10;
    checks++;
    if ({r, i2c_sda_t, i2c_scl_t} !== {9'h04B, 2'b01}) begin failures++; $display("FAIL i2c_write got=%h/%b%b exp=04b/01", r, i2c_sda_t, i2c_scl_t); end
    i2c_sda_i = 0;
    i2c_scl_i = 1;
    rd(8'h03, r);
    checks++;
    if (r !== 9'h006) begin failures++; $display("FAIL i2c_read got=%h exp=006", r); end
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      {i2c_sda_i, i2c_scl_i} = 2'($urandom);
      wr(8'h03, d, r);
      mdl_i2c = d[1:0];
      checks++;
      if ({r, i2c_scl_t, i2c_sda_t} !== {9'h04B, ~d[0], ~d[1]}) begin failures++; $display("FAIL i2c_rand_pins got=%h/%b%b exp=04b/%b%b", r, i2c_scl_t, i2c_sda_t, ~d[0], ~d[1]); end
      rd(8'h03, r);
      checks++;
      if (r !== {1'b0, exp_read(8'h03)}) begin failures++; $display("FAIL i2c_rand_read got=%h exp=%h", r, exp_read(8'h03)); end
    end
  endtask
  task automatic test_random_rw;
    logic [8:0] r;
    logic [7:0] a, d;
    for (int i = 0; i < 6; i++) begin
      a = ($urandom % 2 != 0) ? 8'h00 : 8'($urandom_range(7, 255));
      d = 8'($urandom);
      wr(a, d, r);
      if (a == 8'h00) mdl_led = d;
      checks++;
      if (r !== 9'h04B) begin failures++; $display("FAIL rw_ack a=%h got=%h exp=04b", a, r); end
      rd(a, r);
      checks++;
      if (r !== {1'b0, exp_read(a)} || led !== mdl_led) begin failures++; $display("FAIL rw_read a=%h got=%h led=%h exp=%h led=%h", a, r, led, exp_read(a), mdl_led); end
    end
  endtask
  task automatic test_loopback;
    logic [9:0] exp_g, drv, got;
    logic en;
    exp_g = 10'd0;
    for (int i = 0; i < 40; i++) begin
      drv = 10'($urandom);
      en = (i < 2) || ($urandom % 4 != 0);
      {phy_gmii_rxd, phy_gmii_rx_dv, phy_gmii_rx_er} = drv;
      phy_gmii_clk_en = en;
      @(negedge clk);
      if (en) exp_g = drv;
      got = {phy_gmii_txd, phy_gmii_tx_en, phy_gmii_tx_er};
      checks++;
      if (got !== exp_g) begin failures++; $display("FAIL loopback i=%0d got=%h exp=%h", i, got, exp_g); end
    end
    {phy_gmii_rxd, phy_gmii_rx_dv, phy_gmii_rx_er} = 10'h3FF;
    phy_gmii_clk_en = 1'b1;
    phy_gmii_rst = 1'b1;
    @(negedge clk);
    got = {phy_gmii_txd, phy_gmii_tx_en, phy_gmii_tx_er};
    checks++;
    if (got !== 10'd0) begin failures++; $display("FAIL gmii_rst_clear got=%h exp=000", got); end
    phy_gmii_rst = 1'b0;
    {phy_gmii_rxd, phy_gmii_rx_dv, phy_gmii_rx_er} = 10'd0;
    @(negedge clk);
  endtask
  task automatic test_counters;
    logic [8:0] r;
    int l0, l1, l2;
    l0 = $urandom_range(1, 6);
    l1 = $urandom_range(1, 6);
    l2 = $urandom_range(1, 6);
    phy_gmii_clk_en = 1'b1;
    phy_gmii_rst = 1'b1;
    @(negedge clk);
    phy_gmii_rst = 1'b0;
    pulse(l0, 1'b0);
    pulse(l1, 1'b1);
    pulse(l2, 1'b0);
    rd(8'h05, r);
    checks++;
    if (r !== 9'h003) begin failures++; $display("FAIL rxfrm_three got=%h exp=003", r); end
    rd(8'h06, r);
    checks++;
    if (r !== {1'b0, 8'(l1)}) begin failures++; $display("FAIL rxerr_len got=%h exp=%h", r, 8'(l1)); end
    wr(8'h05, 8'h5A, r);
    rd(8'h05, r);
    checks++;
    if (r !== 9'h000) begin failures++; $display("FAIL rxfrm_clear got=%h exp=000", r); end
    for (int i = 0; i < 256; i++) pulse(1, 1'b0);
    rd(8'h05, r);
    checks++;
    if (r !== 9'h000) begin failures++; $display("FAIL rxfrm_wrap got=%h exp=000", r); end
    wr(8'h06, 8'h00, r);
    rd(8'h06, r);
    checks++;
    if (r !== 9'h000) begin failures++; $display("FAIL rxerr_clear got=%h exp=000", r); end
    pulse(300, 1'b1);
    rd(8'h06, r);
    checks++;
    if (r !== 9'h0FF) begin failures++; $display("FAIL rxerr_sat got=%h exp=0ff", r); end
    rd(8'h05, r);
    checks++;
    if (r !== 9'h001) begin failures++; $display("FAIL rxfrm_after_wrap got=%h exp=001", r); end
  endtask
  task automatic test_ctrl;
    logic [8:0] r;
    logic [9:0] got;
    rd(8'h04, r);
    checks++;
    if (r !== {1'b0, exp_read(8'h04)}) begin failures++; $display("FAIL ctrl_read got=%h exp=%h", r, exp_read(8'h04)); end
    wr(8'h04, 8'h00, r);
    mdl_ctrl = 2'b00;
    checks++;
    if ({r, phy_reset_n} !== {9'h04B, 1'b0}) begin failures++; $display("FAIL ctrl_phy_reset got=%h/%b exp=04b/0", r, phy_reset_n); end
    {phy_gmii_rxd, phy_gmii_rx_dv, phy_gmii_rx_er} = {8'h5A, 2'b11};
    repeat (2) @(negedge clk);
    got = {phy_gmii_txd, phy_gmii_tx_en, phy_gmii_tx_er};
    checks++;
    if (got !== 10'd0) begin failures++; $display("FAIL loopback_off got=%h exp=000", got); end
    {phy_gmii_rxd, phy_gmii_rx_dv, phy_gmii_rx_er} = 10'd0;
    phy_int_n = 1'b0;
    rd(8'h04, r);
    checks++;
    if (r !== {1'b0, exp_read(8'h04)}) begin failures++; $display("FAIL ctrl_int_read got=%h exp=%h", r, exp_read(8'h04)); end
    phy_int_n = 1'b1;
    wr(8'h04, 8'h03, r);
    mdl_ctrl = 2'b11;
    checks++;
    if ({r, phy_reset_n} !== {9'h04B, 1'b1}) begin failures++; $display("FAIL ctrl_restore got=%h/%b exp=04b/1", r, phy_reset_n); end
  endtask
  task automatic test_errors;
    logic [8:0] r;
    send_byte(8'h41, 1'b1);
    get_resp(r);
    checks++;
    if (r !== 9'h03F) begin failures++; $display("FAIL unknown_cmd got=%h exp=03f", r); end
    send_byte(8'h57, 1'b0);
    repeat (30 * DIV) @(negedge clk);
    checks++;
    if (rxq.size() !== 0) begin failures++; $display("FAIL bad_stop got=%0d bytes exp=0", rxq.size()); end
    uart_rxd = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (20 * DIV) @(negedge clk);
    checks++;
    if (rxq.size() !== 0) begin failures++; $display("FAIL start_glitch got=%0d bytes exp=0", rxq.size()); end
    rd(8'h00, r);
    checks++;
    if (r !== {1'b0, mdl_led}) begin failures++; $display("FAIL rearm_read got=%h exp=%h", r, mdl_led); end
  endtask
  task automatic test_cts;
    logic [8:0] r;
    logic saw_low;
    uart_cts = 1'b1;
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    saw_low = 1'b0;
    for (int i = 0; i < 20 * DIV; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) saw_low = 1'b1;
    end
    checks++;
    if (saw_low !== 1'b0) begin failures++; $display("FAIL cts_hold got=%b exp=0", saw_low); end
    uart_cts = 1'b0;
    get_resp(r);
    checks++;
    if (r !== {1'b0, mdl_led}) begin failures++; $display("FAIL cts_release got=%h exp=%h", r, mdl_led); end
  endtask
  task automatic test_reset_midcmd;
    logic [8:0] r;
    send_byte(8'h57, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_led = 8'h00;
    mdl_i2c = 2'b00;
    mdl_ctrl = 2'b11;
    repeat (4) @(negedge clk);
    checks++;
    if (led !== 8'h00) begin failures++; $display("FAIL midcmd_led got=%h exp=00", led); end
    send_byte(8'h00, 1'b1);
    get_resp(r);
    checks++;
    if (r !== 9'h03F) begin failures++; $display("FAIL midcmd_idle got=%h exp=03f", r); end
  endtask
  initial begin
    test_reset;
    test_write_led;
    test_inputs;
    test_i2c;
    test_random_rw;
    test_loopback;
    test_counters;
    test_ctrl;
    test_errors;
    test_cts;
    test_reset_midcmd;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
